hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 55 +++++
 rtl/hazard_detect.sv | 20 ++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control blocks.
//   word_t      : 32-bit datapath word
//   regbits_t   : 5-bit register file index
//   hz_state_t  : hazard controller FSM state (2-bit)
//   STALL_W / STALL_MAX : width and ceiling of the stall counter
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int STALL_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    HALT  = 2'd3
  } hz_state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Port bundle for hazard_ctrl.
//   CLK                      : rising-edge clock (interface port)
//   nRST                     : synchronous active-low reset
//   ihit, dhit               : fetch / data access hit this cycle
//   exmem_dREN, exmem_dWEN   : load / store in EX/MEM
//   idex_dREN, idex_rt       : load in ID/EX and its destination
//   ifid_rs, ifid_rt         : sources of the IF/ID instruction
//   branch_taken, jump       : control-flow redirects
//   memwb_halt               : halt reached MEM/WB
//   pc_en..memwb_en          : advance enables
//   ifid_flush, idex_flush   : bubble insertion
//   halt, stall_cnt          : sticky halt, saturating stall count
// Modports: hc (the controller), tb (the driver side).
interface hazard_ctrl_if
  import cpu_types_pkg::*;
(
  input logic CLK
);
  logic               nRST;
  logic               ihit;
  logic               dhit;
  logic               exmem_dREN;
  logic               exmem_dWEN;
  logic               idex_dREN;
  regbits_t           idex_rt;
  regbits_t           ifid_rs;
  regbits_t           ifid_rt;
  logic               branch_taken;
  logic               jump;
  logic               memwb_halt;
  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               exmem_en;
  logic               memwb_en;
  logic               ifid_flush;
  logic               idex_flush;
  logic               halt;
  logic [STALL_W-1:0] stall_cnt;

  modport hc (
    input  CLK, nRST, ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN,
           idex_rt, ifid_rs, ifid_rt, branch_taken, jump, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halt, stall_cnt
  );

  modport tb (
    input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halt, stall_cnt,
    output nRST, ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN,
           idex_rt, ifid_rs, ifid_rt, branch_taken, jump, memwb_halt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
//   dren_i     : load present in ID/EX
//   dst_i      : destination register of that load
//   rs_i, rt_i : source registers of the IF/ID instruction
//   load_use_o : IF/ID consumes a value the ID/EX load has not produced yet
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     dren_i,
  input  regbits_t dst_i,
  input  regbits_t rs_i,
  input  regbits_t rt_i,
  output logic     load_use_o
);

  // $zero is never a real dependency, so a load targeting r0 never stalls.
  assign load_use_o = dren_i && (dst_i != '0) &&
                      ((dst_i == rs_i) || (dst_i == rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
// Decides each cycle whether the pipe advances (instruction fetch ready and
// any EX/MEM data access satisfied), and which stage enables / flushes to
// raise for taken branches, load-use hazards and jumps. Tracks memory wait
// states with a small FSM, a sticky halt, and a saturating stall counter.
// Ports: single bundle hc (hazard_ctrl_if.hc), see hazard_ctrl_if for list.
module hazard_ctrl
  import cpu_types_pkg::*;
(
  hazard_ctrl_if.hc hc
);

  hz_state_t          state_q, state_d, state_eff;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               mem_op;
  logic               advance;
  logic               load_use;

  logic               pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic               ifid_flush, idex_flush;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == STALL_MAX) ? v : v + 1'b1;
  endfunction

  hazard_detect u_detect (
    .dren_i     (hc.idex_dREN),
    .dst_i      (hc.idex_rt),
    .rs_i       (hc.ifid_rs),
    .rt_i       (hc.ifid_rt),
    .load_use_o (load_use)
  );

  assign mem_op = hc.exmem_dREN | hc.exmem_dWEN;

  // While reset is held the outputs must already look like RUN, even if the
  // register still holds HALT or a wait state from before.
  assign state_eff = hc.nRST ? state_q : RUN;

  // In IWAIT the data hit has already been banked, so only ihit matters.
  always_comb begin
    advance = 1'b0;
    case (state_eff)
      RUN:     advance = hc.ihit & (~mem_op | hc.dhit);
      IWAIT:   advance = hc.ihit;
      default: advance = 1'b0;
    endcase
  end

  // Next-state: IWAIT doubles as the memory of a dhit seen while waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_op && !hc.dhit)                  state_d = DWAIT;
        else if (mem_op && hc.dhit && !hc.ihit)  state_d = IWAIT;
      end
      DWAIT: begin
        if (hc.dhit) state_d = hc.ihit ? RUN : IWAIT;
      end
      IWAIT: begin
        if (hc.ihit) state_d = RUN;
      end
      default: state_d = HALT;
    endcase
    if (hc.memwb_halt) state_d = HALT;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!advance && (state_q != HALT)) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  // Enables / flushes: branch beats load-use beats jump, only when advancing.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = advance;
    memwb_en   = advance;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (advance) begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      idex_en = 1'b1;
      if (hc.branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, let a bubble enter ID/EX.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (hc.jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign hc.pc_en      = pc_en;
  assign hc.ifid_en    = ifid_en;
  assign hc.idex_en    = idex_en;
  assign hc.exmem_en   = exmem_en;
  assign hc.memwb_en   = memwb_en;
  assign hc.ifid_flush = ifid_flush;
  assign hc.idex_flush = idex_flush;
  assign hc.halt       = (state_eff == HALT);
  assign hc.stall_cnt  = stall_cnt_q;

  // State register boundary
  always_ff @(posedge hc.CLK) begin
    if (!hc.nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_ctrl_if hif (.CLK(CLK));
  hazard_ctrl dut (.hc(hif));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: "owes data" / "data banked, awaiting fetch" / halted.
  bit   m_known  = 1'b0;
  bit   m_halted = 1'b0;
  bit   m_dowed  = 1'b0;
  bit   m_dbank  = 1'b0;
  int   m_cnt    = 0;
  bit   e_h, e_dowed, e_dbank, e_lu, e_memop, e_adv;
  logic [7:0] exp_o, got_o;

  always @(negedge CLK) begin
    cyc++;
    e_h     = hif.nRST ? m_halted : 1'b0;
    e_dowed = hif.nRST ? m_dowed  : 1'b0;
    e_dbank = hif.nRST ? m_dbank  : 1'b0;
    e_memop = hif.exmem_dREN || hif.exmem_dWEN;
    e_lu    = hif.idex_dREN && (hif.idex_rt != 5'd0) &&
              (hif.idex_rt == hif.ifid_rs || hif.idex_rt == hif.ifid_rt);
    e_adv   = !e_h && !e_dowed && hif.ihit && (e_dbank || !e_memop || hif.dhit);
    // order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halt
    if (!e_adv)                exp_o = {7'b0, e_h};
    else if (hif.branch_taken) exp_o = 8'b11111110;
    else if (e_lu)             exp_o = 8'b00111010;
    else if (hif.jump)         exp_o = 8'b11111100;
    else                       exp_o = 8'b11111000;
    got_o = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
             hif.ifid_flush, hif.idex_flush, hif.halt};
    if (m_known) begin
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL outs cyc=%0d got %b expected %b", cyc, got_o, exp_o);
      end
      checks++;
      if (hif.stall_cnt !== m_cnt[15:0]) begin
        errors++;
        $display("FAIL stall_cnt cyc=%0d got %0d expected %0d", cyc, hif.stall_cnt, m_cnt);
      end
    end
    // advance model across the coming rising edge
    if (!hif.nRST) begin
      m_halted = 0; m_dowed = 0; m_dbank = 0; m_cnt = 0; m_known = 1;
    end else begin
      if (!m_halted && !e_adv && m_cnt < 65535) m_cnt++;
      if (hif.memwb_halt) m_halted = 1;
      else if (!m_halted) begin
        if (m_dowed) begin
          if (hif.dhit) begin m_dowed = 0; m_dbank = !hif.ihit; end
        end else if (m_dbank) begin
          if (hif.ihit) m_dbank = 0;
        end else if (e_memop && !hif.dhit) m_dowed = 1;
        else if (e_memop && hif.dhit && !hif.ihit) m_dbank = 1;
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hif.ihit = 1; hif.dhit = 0; hif.exmem_dREN = 0; hif.exmem_dWEN = 0;
    hif.idex_dREN = 0; hif.idex_rt = 0; hif.ifid_rs = 0; hif.ifid_rt = 0;
    hif.branch_taken = 0; hif.jump = 0; hif.memwb_halt = 0;
  endtask

  initial begin
    hif.nRST = 0;
    idle();
    repeat (3) tick();
    hif.nRST = 1;
    @(negedge CLK);
    lit("rst_pc_en", hif.pc_en, 1);       lit("rst_ifid_en", hif.ifid_en, 1);
    lit("rst_idex_en", hif.idex_en, 1);   lit("rst_exmem_en", hif.exmem_en, 1);
    lit("rst_memwb_en", hif.memwb_en, 1); lit("rst_ifid_flush", hif.ifid_flush, 0);
    lit("rst_idex_flush", hif.idex_flush, 0);
    lit("rst_stall_cnt", hif.stall_cnt, 0); lit("rst_halt", hif.halt, 0);
    tick();

    // load-use
    hif.idex_dREN = 1; hif.idex_rt = 8; hif.ifid_rs = 8;
    @(negedge CLK);
    lit("lu_pc_en", hif.pc_en, 0); lit("lu_ifid_en", hif.ifid_en, 0);
    lit("lu_idex_flush", hif.idex_flush, 1); lit("lu_idex_en", hif.idex_en, 1);
    tick();
    hif.idex_rt = 0; hif.ifid_rs = 0;
    @(negedge CLK);
    lit("lu_r0_pc_en", hif.pc_en, 1); lit("lu_r0_idex_flush", hif.idex_flush, 0);
    tick();
    hif.idex_rt = 5; hif.ifid_rs = 3; hif.ifid_rt = 5;
    @(negedge CLK);
    lit("lu_rt_pc_en", hif.pc_en, 0);
    tick();

    // branch beats load-use; load-use beats jump
    hif.idex_rt = 8; hif.ifid_rs = 8; hif.ifid_rt = 0; hif.branch_taken = 1;
    @(negedge CLK);
    lit("br_ifid_flush", hif.ifid_flush, 1); lit("br_idex_flush", hif.idex_flush, 1);
    lit("br_pc_en", hif.pc_en, 1);
    tick();
    hif.branch_taken = 0; hif.jump = 1;
    @(negedge CLK);
    lit("jlu_pc_en", hif.pc_en, 0); lit("jlu_ifid_flush", hif.ifid_flush, 0);
    tick();
    hif.idex_dREN = 0;
    @(negedge CLK);
    lit("j_pc_en", hif.pc_en, 1); lit("j_ifid_flush", hif.ifid_flush, 1);
    lit("j_idex_flush", hif.idex_flush, 0);
    tick();
    idle();

    // store: 4 cycles no dhit, dhit without ihit, then ihit
    hif.exmem_dWEN = 1; hif.dhit = 0; hif.ihit = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      lit("dwait_pc_en", hif.pc_en, 0);
      tick();
    end
    hif.dhit = 1; hif.ihit = 0;
    @(negedge CLK);
    lit("dhit_exmem_en", hif.exmem_en, 0);
    tick();
    hif.dhit = 0; hif.ihit = 1;
    @(negedge CLK);
    lit("iwait_pc_en", hif.pc_en, 1); lit("iwait_memwb_en", hif.memwb_en, 1);
    tick();
    hif.exmem_dWEN = 0;
    @(negedge CLK);
    lit("store_stall_cnt", hif.stall_cnt, 5);
    tick();

    // fetch miss in RUN, then RUN->IWAIT->RUN
    hif.ihit = 0;
    tick(); tick();
    hif.exmem_dREN = 1; hif.dhit = 1;
    @(negedge CLK);
    lit("run_iwait_pc_en", hif.pc_en, 0);
    tick();
    hif.dhit = 0; hif.ihit = 1;
    @(negedge CLK);
    lit("iwait_ign_dhit_pc_en", hif.pc_en, 1);
    tick();

    // halt during DWAIT
    tick();
    hif.memwb_halt = 1;
    @(negedge CLK);
    lit("pre_halt", hif.halt, 0);
    tick();
    hif.memwb_halt = 0; hif.dhit = 1; hif.branch_taken = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      lit("halt_held", hif.halt, 1); lit("halt_pc_en", hif.pc_en, 0);
      lit("halt_ifid_flush", hif.ifid_flush, 0); lit("halt_cnt_frozen", hif.stall_cnt, 10);
      tick();
    end

    // reset out of HALT: outputs look like RUN while nRST is low
    hif.nRST = 0;
    @(negedge CLK);
    lit("rst_in_halt_halt", hif.halt, 0); lit("rst_in_halt_flush", hif.ifid_flush, 1);
    tick();
    hif.nRST = 1; idle();
    @(negedge CLK);
    lit("post_halt_rst_cnt", hif.stall_cnt, 0); lit("post_halt_rst_pc_en", hif.pc_en, 1);
    tick();

    // halt and branch together
    hif.branch_taken = 1; hif.memwb_halt = 1;
    @(negedge CLK);
    lit("hb_ifid_flush", hif.ifid_flush, 1); lit("hb_idex_flush", hif.idex_flush, 1);
    tick();
    hif.branch_taken = 0; hif.memwb_halt = 0;
    @(negedge CLK);
    lit("hb_halt", hif.halt, 1); lit("hb_ifid_flush_after", hif.ifid_flush, 0);
    tick();

    // reset mid-DWAIT
    hif.nRST = 0; tick(); hif.nRST = 1;
    hif.exmem_dREN = 1; hif.dhit = 0; tick();
    hif.nRST = 0; hif.exmem_dREN = 0; tick(); hif.nRST = 1;
    @(negedge CLK);
    lit("rst_dwait_pc_en", hif.pc_en, 1);
    tick();

    // reset mid-IWAIT: no banked dhit survives
    hif.exmem_dREN = 1; hif.dhit = 1; hif.ihit = 0; tick();
    hif.nRST = 0; tick(); hif.nRST = 1;
    hif.dhit = 0; hif.ihit = 1;
    @(negedge CLK);
    lit("rst_iwait_pc_en", hif.pc_en, 0);
    tick();

    // saturation
    hif.nRST = 0; idle(); tick();
    hif.nRST = 1; hif.ihit = 0;
    repeat (70000) tick();
    @(negedge CLK);
    lit("sat_cnt", hif.stall_cnt, 32'hFFFF);
    tick();
    repeat (5) tick();
    @(negedge CLK);
    lit("sat_cnt_hold", hif.stall_cnt, 32'hFFFF); lit("sat_halt", hif.halt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
